// File: rtl/par_rd_return_router.sv
// Read-return router for one slave port shared by several masters: gates AR acceptance on tracking
// capacity and steers R beats, in AR acceptance order, to the master that issued each burst.
module par_rd_return_router #(
  parameter int unsigned MasterCount      = 2,
  parameter int unsigned OutstandingDepth = 4
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [MasterCount-1:0]                  ARsel_in,
  input  logic                                    ARVALID_in,
  output logic                                    ARVALID_out,
  input  logic                                    ARREADY_in,
  output logic [MasterCount-1:0]                  ARREADY_out,
  input  logic                                    RVALID_in,
  input  logic                                    RLAST_in,
  output logic                                    RREADY_out,
  output logic [MasterCount-1:0]                  RVALID_out,
  input  logic [MasterCount-1:0]                  RREADY_in,
  output logic [$clog2(OutstandingDepth+1)-1:0]   outstanding
);

  localparam int unsigned IdxW = (MasterCount > 1) ? $clog2(MasterCount) : 1;
  localparam int unsigned PtrW = $clog2(OutstandingDepth);
  localparam int unsigned CntW = $clog2(OutstandingDepth + 1);

  logic [IdxW-1:0] fifo_q [OutstandingDepth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  logic            full, empty, sel_ok, push, pop;
  logic [IdxW-1:0] sel_idx, head;

  assign full  = (count_q == CntW'(OutstandingDepth));
  assign empty = (count_q == '0);
  assign head  = fifo_q[rd_ptr_q];

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
  assign sel_ok = (ARsel_in != '0) && ((ARsel_in & (ARsel_in - 1'b1)) == '0);

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < int'(MasterCount); i++) begin
      if (ARsel_in[i]) begin
        sel_idx = IdxW'(i);
      end
    end
  end

  // Outputs are forced low while reset is asserted, not only after the registers clear.
  always_comb begin
    ARVALID_out = ~rst & ARVALID_in & sel_ok & ~full;
    ARREADY_out = ARsel_in & {MasterCount{~rst & ARREADY_in & sel_ok & ~full}};
    RREADY_out  = ~rst & ~empty & RREADY_in[head];
    RVALID_out  = '0;
    for (int i = 0; i < int'(MasterCount); i++) begin
      RVALID_out[i] = ~rst & ~empty & RVALID_in & (head == IdxW'(i));
    end
  end

  assign push        = ARVALID_out & ARREADY_in;
  assign pop         = RVALID_in & RREADY_out & RLAST_in;
  assign outstanding = count_q;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(OutstandingDepth); i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push) begin
        fifo_q[wr_ptr_q] <= sel_idx;
      end
    end
  end

endmodule

// File: tb/tb_par_rd_return_router.sv
// Bench for par_rd_return_router: queue-based model checked every cycle, plus directed scenarios
// with literal expectations.
module tb_par_rd_return_router;

  localparam int unsigned MC = 2;
  localparam int unsigned D  = 4;
  localparam int unsigned CW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [MC-1:0] ARsel_in = '0;
  logic          ARVALID_in = 1'b0;
  logic          ARVALID_out;
  logic          ARREADY_in = 1'b0;
  logic [MC-1:0] ARREADY_out;
  logic          RVALID_in = 1'b0;
  logic          RLAST_in = 1'b0;
  logic          RREADY_out;
  logic [MC-1:0] RVALID_out;
  logic [MC-1:0] RREADY_in = '0;
  logic [CW-1:0] outstanding;

  par_rd_return_router #(
    .MasterCount     (MC),
    .OutstandingDepth(D)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ARsel_in   (ARsel_in),
    .ARVALID_in (ARVALID_in),
    .ARVALID_out(ARVALID_out),
    .ARREADY_in (ARREADY_in),
    .ARREADY_out(ARREADY_out),
    .RVALID_in  (RVALID_in),
    .RLAST_in   (RLAST_in),
    .RREADY_out (RREADY_out),
    .RVALID_out (RVALID_out),
    .RREADY_in  (RREADY_in),
    .outstanding(outstanding)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: in-order queue of master indices for accepted, not yet completed bursts.
  int mq[$];

  function automatic int sel_index(input logic [MC-1:0] s);
    for (int i = 0; i < int'(MC); i++) if (s[i]) return i;
    return 0;
  endfunction

  function automatic logic m_arv();
    return ARVALID_in && ($countones(ARsel_in) == 1) && (mq.size() < int'(D));
  endfunction

  function automatic logic m_rr();
    if (mq.size() == 0) return 1'b0;
    return RREADY_in[mq[0]];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
    end else begin
      logic do_push, do_pop;
      do_push = m_arv() && ARREADY_in;
      do_pop  = RVALID_in && m_rr() && RLAST_in;
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back(sel_index(ARsel_in));
    end
  end

  always @(negedge clk) begin
    logic [MC-1:0] e_arr, e_rv;
    logic          e_arv, e_rr;
    int            e_cnt;
    if (rst) begin
      e_arv = 0; e_arr = '0; e_rv = '0; e_rr = 0; e_cnt = 0;
    end else begin
      e_arv = m_arv();
      e_arr = (($countones(ARsel_in) == 1) && (mq.size() < int'(D)) && ARREADY_in) ? ARsel_in : '0;
      e_rr  = m_rr();
      e_rv  = (mq.size() > 0 && RVALID_in) ? MC'(1 << mq[0]) : '0;
      e_cnt = mq.size();
    end
    check("model_arvalid", 32'(ARVALID_out), 32'(e_arv));
    check("model_arready", 32'(ARREADY_out), 32'(e_arr));
    check("model_rready", 32'(RREADY_out), 32'(e_rr));
    check("model_rvalid", 32'(RVALID_out), 32'(e_rv));
    check("model_outstanding", 32'(outstanding), 32'(e_cnt));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ARsel_in = '0; ARVALID_in = 0; ARREADY_in = 0;
    RVALID_in = 0; RLAST_in = 0; RREADY_in = '0;
  endtask

  task automatic ar(input logic [MC-1:0] s);
    ARsel_in = s; ARVALID_in = 1; ARREADY_in = 1;
  endtask

  initial begin
    idle();
    step();
    #1;
    check("reset_outstanding", 32'(outstanding), 0);
    check("reset_arvalid", 32'(ARVALID_out), 0);
    step();
    rst = 0;

    // Single burst to M1, four beats.
    ar(2'b10);
    #1;
    check("single_arready", 32'(ARREADY_out), 32'h2);
    check("single_arvalid", 32'(ARVALID_out), 1);
    step();
    idle();
    #1;
    check("single_outstanding1", 32'(outstanding), 1);
    for (int b = 0; b < 4; b++) begin
      RVALID_in = 1; RREADY_in = 2'b10; RLAST_in = (b == 3);
      #1;
      check("single_rvalid", 32'(RVALID_out), 32'h2);
      step();
    end
    idle();
    #1;
    check("single_outstanding0", 32'(outstanding), 0);

    // Fill to full, then a fifth AR must be held off.
    for (int i = 0; i < 4; i++) begin
      ar((i % 2) ? 2'b10 : 2'b01);
      step();
    end
    idle();
    #1;
    check("fill_outstanding4", 32'(outstanding), 4);
    ar(2'b01);
    #1;
    check("full_arvalid", 32'(ARVALID_out), 0);
    check("full_arready", 32'(ARREADY_out), 0);
    step();
    idle();
    for (int k = 0; k < 4; k++) begin
      for (int b = 0; b < 2; b++) begin
        RVALID_in = 1; RREADY_in = 2'b11; RLAST_in = (b == 1);
        #1;
        check("order_rvalid", 32'(RVALID_out), (k % 2) ? 32'h2 : 32'h1);
        step();
      end
    end
    idle();
    #1;
    check("order_drained", 32'(outstanding), 0);

    // Simultaneous push/pop at count 2, long enough to wrap the pointers.
    ar(2'b01); step();
    ar(2'b10); step();
    for (int j = 0; j < 10; j++) begin
      ar((j % 2) ? 2'b10 : 2'b01);
      RVALID_in = 1; RLAST_in = 1; RREADY_in = 2'b11;
      step();
      #1;
      check("pushpop_outstanding", 32'(outstanding), 2);
    end
    idle();
    RVALID_in = 1; RLAST_in = 1; RREADY_in = 2'b11;
    for (int t = 0; t < 8 && outstanding != 0; t++) step();
    idle();
    #1;
    check("pushpop_drained", 32'(outstanding), 0);

    // Backpressure on head master M1 while M0 is ready.
    ar(2'b10); step();
    idle();
    RVALID_in = 1; RLAST_in = 1; RREADY_in = 2'b01;
    #1;
    check("bp_rready", 32'(RREADY_out), 0);
    check("bp_rvalid", 32'(RVALID_out), 32'h2);
    step();
    #1;
    check("bp_held", 32'(outstanding), 1);
    RREADY_in = 2'b10;
    #1;
    check("bp_release_rready", 32'(RREADY_out), 1);
    step();
    idle();
    #1;
    check("bp_done", 32'(outstanding), 0);

    // Illegal selects and a stray beat on an empty tracker.
    ar(2'b11);
    RVALID_in = 1; RLAST_in = 1; RREADY_in = 2'b11;
    #1;
    check("multihot_arvalid", 32'(ARVALID_out), 0);
    check("multihot_arready", 32'(ARREADY_out), 0);
    check("stray_rready", 32'(RREADY_out), 0);
    step();
    ar(2'b00);
    #1;
    check("zero_arvalid", 32'(ARVALID_out), 0);
    step();
    #1;
    check("illegal_outstanding", 32'(outstanding), 0);

    // AR on empty with a beat present: not routed until the next cycle.
    idle();
    ar(2'b01);
    RVALID_in = 1; RREADY_in = 2'b01; RLAST_in = 1;
    #1;
    check("first_push_rvalid", 32'(RVALID_out), 0);
    step();
    ARVALID_in = 0; ARREADY_in = 0;
    #1;
    check("first_push_next_rvalid", 32'(RVALID_out), 32'h1);
    step();
    idle();

    // Reset mid-traffic with three bursts tracked.
    ar(2'b01); step();
    ar(2'b10); step();
    ar(2'b01); step();
    #1;
    check("pre_reset_outstanding", 32'(outstanding), 3);
    RVALID_in = 1; RREADY_in = 2'b11;
    rst = 1;
    #1;
    check("rst_outstanding", 32'(outstanding), 0);
    check("rst_arready", 32'(ARREADY_out), 0);
    check("rst_rvalid", 32'(RVALID_out), 0);
    check("rst_rready", 32'(RREADY_out), 0);
    step();
    rst = 0;
    idle();
    RVALID_in = 1; RREADY_in = 2'b11;
    #1;
    check("post_rst_rready", 32'(RREADY_out), 0);
    check("post_rst_rvalid", 32'(RVALID_out), 0);
    step();
    idle();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
